// File: rtl/camera_pattern_gen.sv
// Camera-side test-pattern source: frame_valid/line_valid/data timing with
// selectable patterns, one pixel per clock, all outputs registered.
module camera_pattern_gen #(
    parameter int COLS      = 640,
    parameter int ROWS      = 480,
    parameter int HBLANK    = 16,
    parameter int FV_TO_LV  = 2,
    parameter int LV_TO_FV  = 2,
    parameter int FRAME_GAP = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    output logic        frame_valid,
    output logic        line_valid,
    output logic [11:0] data,
    output logic        frame_done,
    output logic [15:0] frame_count
);

    localparam int MAX_A = (FV_TO_LV > HBLANK) ? FV_TO_LV : HBLANK;
    localparam int MAX_B = (LV_TO_FV > FRAME_GAP) ? LV_TO_FV : FRAME_GAP;
    localparam int MAX_D = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_D + 1);
    localparam int CLW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [2:0] {IDLE, FV_LEAD, LINE, HBL, FV_TRAIL, GAP} state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [CLW-1:0] col, col_n;
    logic [RW-1:0]  row, row_n;
    logic [1:0]     pat, pat_n;
    logic           fv_n, lv_n, done_n;
    logic [11:0]    data_n, col12, row12;

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        col_n   = col;
        row_n   = row;
        pat_n   = pat;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (enable) begin
                    state_n = FV_LEAD;
                    pat_n   = pattern_sel;
                end
            end
            FV_LEAD: begin
                if (cnt == CW'(FV_TO_LV - 1)) begin
                    state_n = LINE;
                    cnt_n   = '0;
                    row_n   = '0;
                    col_n   = '0;
                end
            end
            LINE: begin
                cnt_n = '0;
                col_n = col + CLW'(1);
                if (col == CLW'(COLS - 1)) begin
                    col_n   = '0;
                    state_n = (row == RW'(ROWS - 1)) ? FV_TRAIL : HBL;
                end
            end
            HBL: begin
                if (cnt == CW'(HBLANK - 1)) begin
                    state_n = LINE;
                    cnt_n   = '0;
                    row_n   = row + RW'(1);
                end
            end
            FV_TRAIL: begin
                if (cnt == CW'(LV_TO_FV - 1)) begin
                    state_n = GAP;
                    cnt_n   = '0;
                end
            end
            GAP: begin
                if (cnt == CW'(FRAME_GAP - 1)) begin
                    cnt_n = '0;
                    if (enable) begin
                        state_n = FV_LEAD;
                        pat_n   = pattern_sel;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from next-state values so the registers line up with state.
    always_comb begin
        fv_n   = (state_n == FV_LEAD) || (state_n == LINE) ||
                 (state_n == HBL) || (state_n == FV_TRAIL);
        lv_n   = (state_n == LINE);
        done_n = (state_n == GAP) && (state != GAP);
        col12  = 12'(col_n);
        row12  = 12'(row_n);
        data_n = '0;
        if (lv_n) begin
            case (pat_n)
                2'b00:   data_n = col12;
                2'b01:   data_n = row12;
                2'b10:   data_n = (col12[3] ^ row12[3]) ? 12'hFFF : 12'h000;
                default: data_n = col12 + row12 + frame_count[11:0];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            col         <= '0;
            row         <= '0;
            pat         <= '0;
            frame_valid <= 1'b0;
            line_valid  <= 1'b0;
            data        <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            col         <= col_n;
            row         <= row_n;
            pat         <= pat_n;
            frame_valid <= fv_n;
            line_valid  <= lv_n;
            data        <= data_n;
            frame_done  <= done_n;
            if (done_n)
                frame_count <= frame_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_camera_pattern_gen.sv
// Self-checking bench for camera_pattern_gen: directed frames plus randomized
// patterns, compared cycle by cycle against an arithmetic frame-timing model.
module tb_camera_pattern_gen;

    localparam int COLS      = 4;
    localparam int ROWS      = 3;
    localparam int HBLANK    = 2;
    localparam int FV_TO_LV  = 2;
    localparam int LV_TO_FV  = 1;
    localparam int FRAME_GAP = 3;
    localparam int PERIOD    = COLS + HBLANK;
    localparam int FV_LEN    = FV_TO_LV + ROWS*COLS + (ROWS-1)*HBLANK + LV_TO_FV;
    localparam int FRAME_LEN = FV_LEN + FRAME_GAP;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = 2'b00;
    logic        frame_valid, line_valid, frame_done;
    logic [11:0] data;
    logic [15:0] frame_count;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_count = 16'd0;

    always #5 clk = ~clk;

    camera_pattern_gen #(
        .COLS(COLS), .ROWS(ROWS), .HBLANK(HBLANK),
        .FV_TO_LV(FV_TO_LV), .LV_TO_FV(LV_TO_FV), .FRAME_GAP(FRAME_GAP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .pattern_sel(pattern_sel),
        .frame_valid(frame_valid), .line_valid(line_valid), .data(data),
        .frame_done(frame_done), .frame_count(frame_count)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string where, input logic efv, input logic elv,
                                 input logic [11:0] ed, input logic edone, input logic [15:0] ecnt);
        check({where, " frame_valid"}, 16'(frame_valid), 16'(efv));
        check({where, " line_valid"},  16'(line_valid),  16'(elv));
        check({where, " data"},        16'(data),        16'(ed));
        check({where, " frame_done"},  16'(frame_done),  16'(edone));
        check({where, " frame_count"}, frame_count,      ecnt);
    endtask

    function automatic logic [11:0] pix(input logic [1:0] pat, input int r, input int c,
                                        input logic [15:0] fc);
        case (pat)
            2'b00:   return 12'(c);
            2'b01:   return 12'(r);
            2'b10:   return (((c / 8) % 2) != ((r / 8) % 2)) ? 12'hFFF : 12'h000;
            default: return 12'(c + r + int'(fc));
        endcase
    endfunction

    task automatic check_idle(input int n, input string where);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_outputs($sformatf("%s idle%0d", where, k), 1'b0, 1'b0, 12'h000, 1'b0, model_count);
        end
    endtask

    // Called one cycle after the frame-start condition has been set up; checks
    // every cycle of the frame and its gap, optionally driving changes mid-frame.
    task automatic play_frame(input string name, input logic [1:0] pat, input int change_at,
                              input logic [1:0] new_sel, input logic new_en, input int abort_at);
        logic [15:0] start;
        logic        efv, elv, edone;
        logic [11:0] ed;
        logic [15:0] ecnt;
        int          j, r, c;
        start = model_count;
        for (int i = 0; i < FRAME_LEN; i++) begin
            @(negedge clk);
            efv = (i < FV_LEN);
            elv = 1'b0;
            ed  = 12'h000;
            if (i >= FV_TO_LV && i < FV_LEN - LV_TO_FV) begin
                j = i - FV_TO_LV;
                r = j / PERIOD;
                c = j % PERIOD;
                if (c < COLS) begin
                    elv = 1'b1;
                    ed  = pix(pat, r, c, start);
                end
            end
            edone = (i == FV_LEN);
            ecnt  = (i >= FV_LEN) ? start + 16'd1 : start;
            check_outputs($sformatf("%s i=%0d", name, i), efv, elv, ed, edone, ecnt);
            if (i == abort_at) begin
                reset_n = 1'b0;
                return;
            end
            if (i == change_at) begin
                pattern_sel = new_sel;
                enable      = new_en;
            end
        end
        model_count = start + 16'd1;
    endtask

    initial begin
        logic [1:0] rp;
        // Reset holds the block idle even with enable asserted.
        reset_n = 1'b0;
        enable = 1'b1;
        pattern_sel = 2'b11;
        repeat (3) @(negedge clk);
        check_outputs("reset", 1'b0, 1'b0, 12'h000, 1'b0, 16'h0000);
        enable = 1'b0;
        reset_n = 1'b1;
        check_idle(3, "post_reset");

        // Single frame, enable high for one cycle.
        pattern_sel = 2'b00;
        enable = 1'b1;
        play_frame("single", 2'b00, 0, 2'($urandom), 1'b0, -1);
        check_idle(4, "single");

        // Continuous frames with pattern 01.
        pattern_sel = 2'b01;
        enable = 1'b1;
        play_frame("cont0", 2'b01, -1, 2'b01, 1'b1, -1);
        play_frame("cont1", 2'b01, -1, 2'b01, 1'b1, -1);
        play_frame("cont2", 2'b01, 10, 2'b01, 1'b0, -1);
        check_idle(3, "cont");

        // enable dropped and pattern changed during line 1.
        pattern_sel = 2'b00;
        enable = 1'b1;
        play_frame("drop", 2'b00, 9, 2'b10, 1'b0, -1);
        check_idle(3, "drop");

        // Reset during line 2 aborts the frame and clears the counter.
        pattern_sel = 2'b00;
        enable = 1'b1;
        play_frame("abort", 2'b00, 0, 2'b00, 1'b0, 15);
        @(negedge clk);
        model_count = 16'd0;
        check_outputs("abort reset", 1'b0, 1'b0, 12'h000, 1'b0, 16'h0000);
        reset_n = 1'b1;
        check_idle(5, "abort");

        // Randomized patterns, mid-frame pattern_sel noise and idle spacing.
        for (int n = 0; n < 6; n++) begin
            rp = 2'($urandom);
            pattern_sel = rp;
            enable = 1'b1;
            play_frame($sformatf("rand%0d", n), rp, $urandom_range(0, FRAME_LEN - 2),
                       2'($urandom), 1'b0, -1);
            check_idle($urandom_range(1, 3), $sformatf("rand%0d", n));
        end

        // Counter wrap with the pattern that includes frame_count.
        @(negedge clk);
        force dut.frame_count = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.frame_count;
        model_count = 16'hFFFF;
        check_idle(2, "preset");
        pattern_sel = 2'b11;
        enable = 1'b1;
        play_frame("wrap", 2'b11, -1, 2'b11, 1'b1, -1);
        play_frame("after_wrap", 2'b11, 5, 2'b11, 1'b0, -1);
        check_idle(3, "wrap");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/camera_pattern_gen.md
CAMERA_PATTERN_GEN -- requirements
Module: camera_pattern_gen

Interface
REQ-001 The block SHALL have a parameter COLS, default 640: active pixels per line (>=1).
REQ-002 The block SHALL have a parameter ROWS, default 480: active lines per frame (>=1).
REQ-003 The block SHALL have a parameter HBLANK, default 16: line_valid-low cycles between lines inside a frame (>=1).
REQ-004 The block SHALL have a parameter FV_TO_LV, default 2: cycles with frame_valid high before the first line_valid (>=1).
REQ-005 The block SHALL have a parameter LV_TO_FV, default 2: cycles with frame_valid high after the last line_valid (>=1).
REQ-006 The block SHALL have a parameter FRAME_GAP, default 8: frame_valid-low cycles between frames (>=1).
REQ-007 The block SHALL have port clk, input, 1 bit: single clock; one pixel per cycle.
REQ-008 The block SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-009 The block SHALL have port enable, input, 1 bit: request continuous frame generation.
REQ-010 The block SHALL have port pattern_sel, input, 2 bits: test-pattern select.
REQ-011 The block SHALL have port frame_valid, output, 1 bit: camera-side frame strobe.
REQ-012 The block SHALL have port line_valid, output, 1 bit: camera-side line strobe.
REQ-013 The block SHALL have port data, output, 12 bits: pixel value.
REQ-014 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of each frame.
REQ-015 The block SHALL have port frame_count, output, 16 bits: completed-frame counter.

Function
REQ-016 All outputs SHALL be registered; the block SHALL drive the same frame_valid/line_valid/data timing the camera controller's camera input port consumes.
REQ-017 The FSM SHALL have states IDLE, FV_LEAD, LINE, HBL, FV_TRAIL, GAP.
REQ-018 In IDLE, frame_valid=0 and line_valid=0; when enable=1 is sampled, the FSM SHALL enter FV_LEAD, and frame_valid SHALL be 1 on the next cycle (latency 1).
REQ-019 FV_LEAD SHALL last FV_TO_LV cycles with frame_valid=1 and line_valid=0, then go to LINE with row=0.
REQ-020 LINE SHALL last COLS cycles with frame_valid=1 and line_valid=1; col SHALL count 0..COLS-1.
REQ-021 At the end of LINE: if row=ROWS-1, the FSM SHALL go to FV_TRAIL; otherwise it SHALL go to HBL (HBLANK cycles, frame_valid=1, line_valid=0), then to LINE with row+1.
REQ-022 FV_TRAIL SHALL last LV_TO_FV cycles with frame_valid=1, then go to GAP.
REQ-023 GAP SHALL last FRAME_GAP cycles with frame_valid=0; frame_done=1 on the first GAP cycle only; frame_count SHALL increment on that same cycle and wrap 0xFFFF->0x0000.
REQ-024 At the end of GAP: enable=1 -> FV_LEAD; enable=0 -> IDLE.
REQ-025 enable SHALL be sampled only in IDLE and at the end of GAP; deasserting enable mid-frame SHALL not truncate the frame.
REQ-026 pattern_sel SHALL be latched on entry to FV_LEAD and held constant for the whole frame.
REQ-027 data SHALL be 0 whenever line_valid=0.
REQ-028 While line_valid=1, data SHALL follow pattern_sel as follows, truncated to the low 12 bits:
- 00: col
- 01: row
- 10: 0xFFF if col[3] XOR row[3], else 0x000
- 11: (col + row + frame_count)
REQ-029 Each frame SHALL contain exactly ROWS line_valid pulses of exactly COLS cycles; the frame_valid-high length SHALL be FV_TO_LV + ROWS*COLS + (ROWS-1)*HBLANK + LV_TO_FV.

Reset
REQ-030 When reset_n=0 is sampled, the next cycle SHALL have state=IDLE, frame_valid=0, line_valid=0, data=0, frame_done=0, frame_count=0, row=0, col=0, and latched pattern=0.
REQ-031 A reset asserted mid-frame SHALL abort the frame immediately, with no frame_done pulse and no frame_count increment.
REQ-032 After reset_n returns to 1, a new frame SHALL start only via the IDLE/enable rule.

Verification
All scenarios use COLS=4, ROWS=3, HBLANK=2, FV_TO_LV=2, LV_TO_FV=1, FRAME_GAP=3.
REQ-033 Single frame: enable=1 for one cycle in IDLE, pattern 00 -> frame_valid high for 19 cycles; 3 line_valid pulses of 4 cycles; data 0,1,2,3 on each line; one frame_done; frame_count=1; return to IDLE.
REQ-034 Continuous: enable held at 1 for 3 frames, pattern 01 -> data=row (0/1/2); frame_valid low for exactly 3 cycles between frames; frame_count=3.
REQ-035 Mid-frame drop and pattern change: enable dropped, and pattern_sel changed 00->10, during line 1 -> frame completes with pattern 00 unchanged; block returns to IDLE after GAP.
REQ-036 Reset mid-line: reset_n=0 during line 2 -> next cycle all outputs 0, frame_count unchanged at 0, no frame_done pulse.
REQ-037 Wrap: frame_count forced to 0xFFFF with pattern 11 -> after the frame, frame_count=0x0000; on the first line of the next frame, data=0,1,2,3.
REQ-038 Default parameters (640x480): frame_valid-high length = 2 + 307200 + 479*16 + 2 = 314868 cycles.
